multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
- Multi-cycle main controller for the MIPS datapath. It replaces per-instruction combinational control with an FSM that steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- It shares a single memory port between instruction fetch and data access, waits on memory handshake, and counts retired instructions.
- It sits between the IR (which drives opcode/funct) and the datapath muxes, register file, ALU and memory.

Parameters:
- WAIT_MAX, 15: maximum cycles spent waiting for mem_ready in FETCH or MEM before faulting.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- funct  in  6  IR[5:0]; valid from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access complete this cycle.
- pc_write  out  1  PC load enable.
- pc_src  out  2  next-PC select: 0=ALU (PC+4), 1=ALUOut (branch target), 2=jump target, 3=rs (jr).
- ir_write  out  1  IR load enable.
- iord  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_read  out  2  read size: 0=none, 1=byte, 2=half, 3=word.
- mem_write  out  2  write size, same encoding as mem_read.
- reg_write  out  1  register file write enable.
- reg_dst  out  2  destination select: 0=rt, 1=rd, 2=$31.
- mem_to_reg  out  2  write-back source: 0=ALUOut, 1=MDR, 2=PC.
- alu_src_a  out  1  ALU A select: 0=PC, 1=rs.
- alu_src_b  out  2  ALU B select: 0=rt, 1=const 4, 2=sign-extended imm, 3=imm<<2.
- alu_ctrl  out  4  ALU op: 0000=and, 0001=or, 0010=add, 0110=sub, 0111=slt, 1000=lui.
- state  out  3  current state, for debug.
- illegal  out  1  one-cycle pulse on an undecodable instruction.
- fault  out  1  sticky memory-timeout flag.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset (rst_n low, asynchronous): state=FETCH, wait counter=0, retired=0, fault=0. While rst_n is low, all control outputs are forced to 0.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=7.
- Output timing: control outputs are combinational from state, opcode and funct. Counters and state are registered.
- FETCH:
  - Drives mem_read=3, iord=0, alu_src_a=0, alu_src_b=1, alu_ctrl=0010.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=0, next state DECODE.
  - Otherwise the wait counter increments. Reaching WAIT_MAX moves to FAULT.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=3, alu_ctrl=0010 to form the branch target in ALUOut.
  - j (000010): pc_write=1, pc_src=2, next FETCH, retired+1.
  - jal (000011): as j, plus reg_write=1, reg_dst=2, mem_to_reg=2.
  - Legal opcodes: 000000 (with a legal funct), 001000, 001100, 001101, 001010, 001111, 100000, 100001, 100011, 101000, 101001, 101011, 000100, 000101, 000001. These go to EXEC.
  - Any other opcode or funct: illegal=1 for one cycle, next FETCH, no writes, retired unchanged.
- EXEC:
  - R-type: alu_src_a=1, alu_src_b=0; funct 100000→add, 100010→sub, 100100→and, 100101→or, 101010→slt. Next WB.
  - jr (funct 001000): pc_write=1, pc_src=3, no reg_write, next FETCH, retired+1.
  - addi/andi/ori/slti/lui: alu_src_a=1, alu_src_b=2, alu_ctrl 0010/0000/0001/0111/1000 respectively. Next WB.
  - Loads and stores: alu_src_a=1, alu_src_b=2, alu_ctrl=0010, next MEM.
  - beq/bne: alu_src_a=1, alu_src_b=0, alu_ctrl=0110. pc_write=zero for beq and !zero for bne; pc_src=1. Next FETCH, retired+1.
  - bgez: alu_src_a=1, alu_src_b=2 with the datapath immediate path zeroed, alu_ctrl=0111. pc_write=zero, pc_src=1. Next FETCH, retired+1.
- MEM:
  - Drives iord=1. Loads drive mem_read 1/2/3 for lb/lh/lw; stores drive mem_write 1/2/3 for sb/sh/sw.
  - Outputs are held until mem_ready=1. On mem_ready, loads go to WB; stores go to FETCH with retired+1.
  - Timeout behaves as in FETCH.
- WB:
  - reg_write=1, one cycle. R-type: reg_dst=1, mem_to_reg=0. Immediates: reg_dst=0, mem_to_reg=0. Loads: reg_dst=0, mem_to_reg=1.
  - Next FETCH, retired+1.
- Wait counter: cleared on every state change. mem_ready arriving on the same cycle the counter reaches WAIT_MAX counts as success.
- FAULT: all control outputs 0, fault=1, state held until reset.
- retired wraps modulo 2^CNT_W.
- Reset asserted mid-instruction aborts it with no further writes. A pending memory access is dropped.

Test Plan:
- Reset release, mem_ready tied 1, IR=add (000000/100000) → states 0,1,2,4,0; reg_write=1 only in WB with reg_dst=1; retired=1 after 4 cycles.
- lw with mem_ready low 3 cycles in MEM → mem_read=3, iord=1 held 4 cycles; WB mem_to_reg=1; retired+1; total 8 cycles with 1-cycle FETCH.
- beq with zero=1, then with zero=0 → pc_write=1, pc_src=1 in EXEC for the first; pc_write=0 for the second; both return to FETCH.
- jal → DECODE drives pc_write=1, pc_src=2, reg_write=1, reg_dst=2, mem_to_reg=2; 2-cycle instruction.
- opcode 111111 → illegal pulses 1 cycle in DECODE, next state FETCH, retired unchanged, no writes.
- mem_ready held 0 in FETCH for 15 cycles → state=7, fault=1, all controls 0; rst_n pulse low → state=0, fault=0, retired=0.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// ============================================================================
// Module   : multicycle_sequencer
// Purpose  : Multi-cycle MIPS main controller (FETCH/DECODE/EXEC/MEM/WB)
//            sharing one memory port between fetch and data access.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_sequencer #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ir_write,
    output logic             iord,
    output logic [1:0]       mem_read,
    output logic [1:0]       mem_write,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_ctrl,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    localparam int c_WAIT_W = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd7
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [c_WAIT_W-1:0] r_wait;
    logic [c_WAIT_W-1:0] w_wait_cnt_nxt;
    logic                w_wait_hit, w_wait_inc, w_retire;
    logic [CNT_W-1:0]    r_retired;
    logic                r_fault;

    logic       w_pc_write, w_ir_write, w_iord, w_reg_write, w_alu_src_a, w_illegal;
    logic [1:0] w_pc_src, w_mem_read, w_mem_write, w_reg_dst, w_mem_to_reg, w_alu_src_b;
    logic [3:0] w_alu_ctrl;

    logic w_is_r, w_r_ok, w_is_jr, w_is_imm, w_is_load, w_is_store;
    logic w_is_beq, w_is_bne, w_is_bgez, w_is_j, w_is_jal, w_legal;
    logic [1:0] w_size;
    logic [3:0] w_r_alu, w_imm_alu;

    assign w_wait_cnt_nxt = r_wait + c_WAIT_W'(1);
    // Ready on the cycle the count would reach WAIT_MAX still wins.
    assign w_wait_hit     = (w_wait_cnt_nxt >= c_WAIT_W'(WAIT_MAX));

    always_comb begin
        w_is_r     = (opcode == 6'b000000);
        w_is_jr    = w_is_r && (funct == 6'b001000);
        w_is_imm   = (opcode == 6'b001000) || (opcode == 6'b001100) || (opcode == 6'b001101) ||
                     (opcode == 6'b001010) || (opcode == 6'b001111);
        w_is_load  = (opcode == 6'b100000) || (opcode == 6'b100001) || (opcode == 6'b100011);
        w_is_store = (opcode == 6'b101000) || (opcode == 6'b101001) || (opcode == 6'b101011);
        w_is_beq   = (opcode == 6'b000100);
        w_is_bne   = (opcode == 6'b000101);
        w_is_bgez  = (opcode == 6'b000001);
        w_is_j     = (opcode == 6'b000010);
        w_is_jal   = (opcode == 6'b000011);

        w_r_ok  = 1'b1;
        w_r_alu = 4'b0000;
        case (funct)
            6'b100000: w_r_alu = 4'b0010;
            6'b100010: w_r_alu = 4'b0110;
            6'b100100: w_r_alu = 4'b0000;
            6'b100101: w_r_alu = 4'b0001;
            6'b101010: w_r_alu = 4'b0111;
            6'b001000: w_r_alu = 4'b0000;
            default:   w_r_ok  = 1'b0;
        endcase

        case (opcode)
            6'b001100: w_imm_alu = 4'b0000;
            6'b001101: w_imm_alu = 4'b0001;
            6'b001010: w_imm_alu = 4'b0111;
            6'b001111: w_imm_alu = 4'b1000;
            default:   w_imm_alu = 4'b0010;
        endcase

        // Access size is encoded in the low opcode bits: b/h/w = 00/01/11.
        case (opcode[1:0])
            2'b00:   w_size = 2'd1;
            2'b01:   w_size = 2'd2;
            default: w_size = 2'd3;
        endcase

        w_legal = (w_is_r && w_r_ok) || w_is_imm || w_is_load || w_is_store ||
                  w_is_beq || w_is_bne || w_is_bgez;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_wait_inc   = 1'b0;
        w_retire     = 1'b0;
        w_pc_write   = 1'b0;
        w_pc_src     = 2'd0;
        w_ir_write   = 1'b0;
        w_iord       = 1'b0;
        w_mem_read   = 2'd0;
        w_mem_write  = 2'd0;
        w_reg_write  = 1'b0;
        w_reg_dst    = 2'd0;
        w_mem_to_reg = 2'd0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = 2'd0;
        w_alu_ctrl   = 4'b0000;
        w_illegal    = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_mem_read  = 2'd3;
                w_alu_src_b = 2'd1;
                w_alu_ctrl  = 4'b0010;
                if (mem_ready) begin
                    w_ir_write  = 1'b1;
                    w_pc_write  = 1'b1;
                    w_state_nxt = S_DECODE;
                end else begin
                    w_wait_inc = 1'b1;
                    if (w_wait_hit) w_state_nxt = S_FAULT;
                end
            end
            S_DECODE: begin
                w_alu_src_b = 2'd3;
                w_alu_ctrl  = 4'b0010;
                if (w_is_j || w_is_jal) begin
                    w_pc_write  = 1'b1;
                    w_pc_src    = 2'd2;
                    w_retire    = 1'b1;
                    w_state_nxt = S_FETCH;
                    if (w_is_jal) begin
                        w_reg_write  = 1'b1;
                        w_reg_dst    = 2'd2;
                        w_mem_to_reg = 2'd2;
                    end
                end else if (w_legal) begin
                    w_state_nxt = S_EXEC;
                end else begin
                    w_illegal   = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            S_EXEC: begin
                w_alu_src_a = 1'b1;
                w_state_nxt = S_FETCH;
                if (w_is_r) begin
                    w_alu_ctrl = w_r_alu;
                    if (w_is_jr) begin
                        w_pc_write = 1'b1;
                        w_pc_src   = 2'd3;
                        w_retire   = 1'b1;
                    end else begin
                        w_state_nxt = S_WB;
                    end
                end else if (w_is_imm) begin
                    w_alu_src_b = 2'd2;
                    w_alu_ctrl  = w_imm_alu;
                    w_state_nxt = S_WB;
                end else if (w_is_load || w_is_store) begin
                    w_alu_src_b = 2'd2;
                    w_alu_ctrl  = 4'b0010;
                    w_state_nxt = S_MEM;
                end else if (w_is_beq || w_is_bne) begin
                    w_alu_ctrl = 4'b0110;
                    w_pc_write = w_is_beq ? zero : !zero;
                    w_pc_src   = 2'd1;
                    w_retire   = 1'b1;
                end else if (w_is_bgez) begin
                    w_alu_src_b = 2'd2;
                    w_alu_ctrl  = 4'b0111;
                    w_pc_write  = zero;
                    w_pc_src    = 2'd1;
                    w_retire    = 1'b1;
                end
            end
            S_MEM: begin
                w_iord = 1'b1;
                if (w_is_load)  w_mem_read  = w_size;
                if (w_is_store) w_mem_write = w_size;
                if (mem_ready) begin
                    w_state_nxt = w_is_load ? S_WB : S_FETCH;
                    w_retire    = !w_is_load;
                end else begin
                    w_wait_inc = 1'b1;
                    if (w_wait_hit) w_state_nxt = S_FAULT;
                end
            end
            S_WB: begin
                w_reg_write  = 1'b1;
                w_reg_dst    = w_is_r ? 2'd1 : 2'd0;
                w_mem_to_reg = w_is_load ? 2'd1 : 2'd0;
                w_retire     = 1'b1;
                w_state_nxt  = S_FETCH;
            end
            S_FAULT: w_state_nxt = S_FAULT;
            default: w_state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_wait    <= '0;
            r_retired <= '0;
            r_fault   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) r_wait <= '0;
            else if (w_wait_inc)        r_wait <= w_wait_cnt_nxt;
            if (w_retire)                r_retired <= r_retired + CNT_W'(1);
            if (w_state_nxt == S_FAULT)  r_fault   <= 1'b1;
        end
    end

    // Controls are gated by rst_n so nothing is driven while reset is held.
    assign pc_write   = rst_n & w_pc_write;
    assign pc_src     = rst_n ? w_pc_src     : 2'd0;
    assign ir_write   = rst_n & w_ir_write;
    assign iord       = rst_n & w_iord;
    assign mem_read   = rst_n ? w_mem_read   : 2'd0;
    assign mem_write  = rst_n ? w_mem_write  : 2'd0;
    assign reg_write  = rst_n & w_reg_write;
    assign reg_dst    = rst_n ? w_reg_dst    : 2'd0;
    assign mem_to_reg = rst_n ? w_mem_to_reg : 2'd0;
    assign alu_src_a  = rst_n & w_alu_src_a;
    assign alu_src_b  = rst_n ? w_alu_src_b  : 2'd0;
    assign alu_ctrl   = rst_n ? w_alu_ctrl   : 4'd0;
    assign illegal    = rst_n & w_illegal;
    assign state      = r_state;
    assign fault      = r_fault;
    assign retired    = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
// ============================================================================
// Module   : tb_multicycle_sequencer
// Purpose  : Instruction-level timeline model checked against the sequencer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multicycle_sequencer;

    localparam int WAIT_MAX = 15;
    localparam int CNT_W    = 32;

    localparam int K_R = 0, K_JR = 1, K_IMM = 2, K_LOAD = 3, K_STORE = 4, K_BEQ = 5;
    localparam int K_BNE = 6, K_BGEZ = 7, K_J = 8, K_JAL = 9, K_ILL = 10;

    logic             clk, rst_n;
    logic [5:0]       opcode, funct;
    logic             zero, mem_ready;
    logic             pc_write, ir_write, iord, reg_write, alu_src_a, illegal, fault;
    logic [1:0]       pc_src, mem_read, mem_write, reg_dst, mem_to_reg, alu_src_b;
    logic [3:0]       alu_ctrl;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;

    int errors  = 0;
    int checks  = 0;
    int mdl_ret = 0;
    int ncyc    = 0;
    int n0;

    multicycle_sequencer #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .state(state), .illegal(illegal),
        .fault(fault), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    wire [21:0] dut_ctl = {pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write,
                           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, illegal};

    function automatic logic [21:0] mk(input logic pcw, input logic [1:0] pcs, input logic irw,
                                       input logic io, input logic [1:0] mr, input logic [1:0] mw,
                                       input logic rw, input logic [1:0] rd, input logic [1:0] mtr,
                                       input logic asa, input logic [1:0] asb,
                                       input logic [3:0] actl, input logic ill);
        return {pcw, pcs, irw, io, mr, mw, rw, rd, mtr, asa, asb, actl, ill};
    endfunction

    function automatic int kind(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b000000: begin
                if (fn == 6'b001000) return K_JR;
                if (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
                    fn == 6'b100101 || fn == 6'b101010) return K_R;
                return K_ILL;
            end
            6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b001111: return K_IMM;
            6'b100000, 6'b100001, 6'b100011: return K_LOAD;
            6'b101000, 6'b101001, 6'b101011: return K_STORE;
            6'b000100: return K_BEQ;
            6'b000101: return K_BNE;
            6'b000001: return K_BGEZ;
            6'b000010: return K_J;
            6'b000011: return K_JAL;
            default:   return K_ILL;
        endcase
    endfunction

    function automatic logic [3:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 4'b0010;
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            default:   return 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] imm_alu(input logic [5:0] op);
        case (op)
            6'b001000: return 4'b0010;
            6'b001100: return 4'b0000;
            6'b001101: return 4'b0001;
            6'b001010: return 4'b0111;
            default:   return 4'b1000;
        endcase
    endfunction

    function automatic logic [1:0] msize(input logic [5:0] op);
        case (op)
            6'b100000, 6'b101000: return 2'd1;
            6'b100001, 6'b101001: return 2'd2;
            default:              return 2'd3;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, compare at the falling edge, step past the rising edge.
    task automatic cyc(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic rdy,
                       input logic [21:0] ec, input logic [2:0] es, input bit ret, input string tag);
        opcode = op; funct = fn; zero = z; mem_ready = rdy;
        @(negedge clk);
        check({tag, " ctl"}, 64'(dut_ctl), 64'(ec));
        check({tag, " state"}, 64'(state), 64'(es));
        check({tag, " fault"}, 64'(fault), 64'(es == 3'd7));
        check({tag, " retired"}, 64'(retired), 64'(mdl_ret));
        @(posedge clk);
        #1;
        ncyc++;
        if (ret) mdl_ret++;
    endtask

    // Expected timeline of one instruction, derived from the control tables.
    task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input int fwait, input int mwait, input int abort_at);
        int k;
        logic [21:0] ec;
        k = kind(op, fn);
        for (int i = 0; i < fwait && i < WAIT_MAX; i++)
            cyc(op, fn, z, 1'b0, mk(0,0,0,0,3,0,0,0,0,0,1,4'b0010,0), 3'd0, 1'b0, "fetch-wait");
        if (fwait >= WAIT_MAX) return;
        cyc(op, fn, z, 1'b1, mk(1,0,1,0,3,0,0,0,0,0,1,4'b0010,0), 3'd0, 1'b0, "fetch");

        case (k)
            K_J:   begin cyc(op, fn, z, 1'b1, mk(1,2,0,0,0,0,0,0,0,0,3,4'b0010,0), 3'd1, 1'b1, "dec-j"); return; end
            K_JAL: begin cyc(op, fn, z, 1'b1, mk(1,2,0,0,0,0,1,2,2,0,3,4'b0010,0), 3'd1, 1'b1, "dec-jal"); return; end
            K_ILL: begin cyc(op, fn, z, 1'b1, mk(0,0,0,0,0,0,0,0,0,0,3,4'b0010,1), 3'd1, 1'b0, "dec-ill"); return; end
            default: cyc(op, fn, z, 1'b1, mk(0,0,0,0,0,0,0,0,0,0,3,4'b0010,0), 3'd1, 1'b0, "decode");
        endcase

        case (k)
            K_R:    cyc(op, fn, z, 1'b1, mk(0,0,0,0,0,0,0,0,0,1,0,r_alu(fn),0), 3'd2, 1'b0, "exec-r");
            K_JR:   begin cyc(op, fn, z, 1'b1, mk(1,3,0,0,0,0,0,0,0,1,0,4'b0000,0), 3'd2, 1'b1, "exec-jr"); return; end
            K_IMM:  cyc(op, fn, z, 1'b1, mk(0,0,0,0,0,0,0,0,0,1,2,imm_alu(op),0), 3'd2, 1'b0, "exec-imm");
            K_BEQ:  begin cyc(op, fn, z, 1'b1, mk(z,1,0,0,0,0,0,0,0,1,0,4'b0110,0), 3'd2, 1'b1, "exec-beq"); return; end
            K_BNE:  begin cyc(op, fn, z, 1'b1, mk(!z,1,0,0,0,0,0,0,0,1,0,4'b0110,0), 3'd2, 1'b1, "exec-bne"); return; end
            K_BGEZ: begin cyc(op, fn, z, 1'b1, mk(z,1,0,0,0,0,0,0,0,1,2,4'b0111,0), 3'd2, 1'b1, "exec-bgez"); return; end
            default: cyc(op, fn, z, 1'b1, mk(0,0,0,0,0,0,0,0,0,1,2,4'b0010,0), 3'd2, 1'b0, "exec-mem");
        endcase

        if (k == K_LOAD || k == K_STORE) begin
            ec = mk(0,0,0,1, (k == K_LOAD) ? msize(op) : 2'd0, (k == K_STORE) ? msize(op) : 2'd0,
                    0,0,0,0,0,4'b0000,0);
            for (int i = 0; i < mwait && i < WAIT_MAX; i++) begin
                if (i == abort_at) return;
                cyc(op, fn, z, 1'b0, ec, 3'd3, 1'b0, "mem-wait");
            end
            if (mwait >= WAIT_MAX) return;
            cyc(op, fn, z, 1'b1, ec, 3'd3, (k == K_STORE), "mem");
            if (k == K_STORE) return;
        end

        cyc(op, fn, z, 1'b1, mk(0,0,0,0,0,0,1, (k == K_R) ? 2'd1 : 2'd0, (k == K_LOAD) ? 2'd1 : 2'd0,
                                 0,0,4'b0000,0), 3'd4, 1'b1, "wb");
    endtask

    task automatic fault_hold(input int n);
        for (int i = 0; i < n; i++)
            cyc(6'b000000, 6'b100000, 1'b0, 1'b1, 22'd0, 3'd7, 1'b0, "fault-hold");
    endtask

    // Asserts reset between edges, holds it across a rising edge, releases before the next cycle.
    task automatic do_reset();
        mem_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rst ctl", 64'(dut_ctl), 64'd0);
        check("rst state", 64'(state), 64'd0);
        check("rst fault", 64'(fault), 64'd0);
        check("rst retired", 64'(retired), 64'd0);
        mdl_ret = 0;
        @(posedge clk);
        #1;
        check("rst held ctl", 64'(dut_ctl), 64'd0);
        check("rst held state", 64'(state), 64'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        #2;
        do_reset();

        instr(6'b000000, 6'b100000, 0, 0, 0, -1);              // add
        check("add retired literal", 64'(retired), 64'd1);
        n0 = ncyc;
        instr(6'b100011, 6'b000000, 0, 0, 3, -1);              // lw, 3 waits in MEM
        check("lw cycle count", 64'(ncyc - n0), 64'd8);
        check("lw retired literal", 64'(retired), 64'd2);
        instr(6'b000100, 6'b000000, 1, 0, 0, -1);              // beq taken
        instr(6'b000100, 6'b000000, 0, 0, 0, -1);              // beq not taken
        n0 = ncyc;
        instr(6'b000011, 6'b000000, 0, 0, 0, -1);              // jal
        check("jal cycle count", 64'(ncyc - n0), 64'd2);
        check("jal retired literal", 64'(retired), 64'd5);
        instr(6'b111111, 6'b000000, 0, 0, 0, -1);              // undefined opcode
        instr(6'b000000, 6'b000001, 0, 0, 0, -1);              // undefined funct
        check("illegal retired literal", 64'(retired), 64'd5);

        instr(6'b000000, 6'b100010, 0, 0, 0, -1);              // sub
        instr(6'b000000, 6'b100100, 0, 0, 0, -1);              // and
        instr(6'b000000, 6'b100101, 0, 0, 0, -1);              // or
        instr(6'b000000, 6'b101010, 0, 0, 0, -1);              // slt
        instr(6'b001000, 6'b000000, 0, 0, 0, -1);              // addi
        instr(6'b001100, 6'b000000, 0, 0, 0, -1);              // andi
        instr(6'b001101, 6'b000000, 0, 0, 0, -1);              // ori
        instr(6'b001010, 6'b000000, 0, 0, 0, -1);              // slti
        instr(6'b001111, 6'b000000, 0, 0, 0, -1);              // lui
        instr(6'b100000, 6'b000000, 0, 0, 0, -1);              // lb
        instr(6'b100001, 6'b000000, 0, 0, 1, -1);              // lh
        instr(6'b101000, 6'b000000, 0, 0, 0, -1);              // sb
        instr(6'b101001, 6'b000000, 0, 0, 2, -1);              // sh
        instr(6'b101011, 6'b000000, 0, 0, 0, -1);              // sw
        check("store retired literal", 64'(retired), 64'd19);
        instr(6'b000101, 6'b000000, 0, 0, 0, -1);              // bne taken
        instr(6'b000101, 6'b000000, 1, 0, 0, -1);              // bne not taken
        instr(6'b000001, 6'b000000, 1, 0, 0, -1);              // bgez
        instr(6'b000010, 6'b000000, 0, 0, 0, -1);              // j
        instr(6'b000000, 6'b001000, 0, 0, 0, -1);              // jr
        check("jr retired literal", 64'(retired), 64'd24);
        instr(6'b001101, 6'b000000, 0, WAIT_MAX - 1, 0, -1);   // ready on the last allowed cycle
        check("late ready state", 64'(state), 64'd0);
        check("late ready retired", 64'(retired), 64'd25);

        instr(6'b100011, 6'b000000, 0, 0, 5, 2);               // lw aborted by reset in MEM
        do_reset();
        instr(6'b000000, 6'b100000, 0, WAIT_MAX, 0, -1);       // fetch timeout
        fault_hold(3);
        check("fetch timeout fault literal", 64'(fault), 64'd1);
        do_reset();
        instr(6'b000000, 6'b100101, 0, 0, 0, -1);
        check("post-reset retired literal", 64'(retired), 64'd1);
        instr(6'b101011, 6'b000000, 0, 0, WAIT_MAX, -1);       // data-access timeout
        fault_hold(2);
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
